// File: rtl/keypad_event_queue_pkg.sv
// Shared types and helpers for the keypad event queue: key code width,
// frame classification, debounce FSM states and the queued event layout.
package keypad_pkg;

    localparam int KEY_CODE_W = 4;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        FR_NONE  = 2'd0,
        FR_ONE   = 2'd1,
        FR_MULTI = 2'd2
    } frame_res_e;

    typedef enum logic [1:0] {
        KS_IDLE    = 2'd0,
        KS_CAND    = 2'd1,
        KS_PRESSED = 2'd2
    } key_state_e;

    typedef struct packed {
        logic [KEY_CODE_W-1:0] code;
        logic                  is_release;
    } key_evt_t;

    // Frame counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// Synchronous event FIFO with registered head/valid/count, drop-on-full
// and a sticky overflow flag.
module keypad_evt_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 5,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [W-1:0]     push_data_i,
    input  logic             pop_ready_i,
    output logic             valid_o,
    output logic [W-1:0]     head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             valid_q;
    logic             ovf_q;
    logic [W-1:0]     head_q;
    logic             full_s;
    logic             empty_s;
    logic             pop_s;
    logic             push_acc_s;
    logic             drop_s;
    logic [PTR_W-1:0] rd_next_s;

    // Handshake qualification and next occupancy.
    always_comb begin
        full_s     = (count_q == CNT_W'(DEPTH));
        empty_s    = (count_q == {CNT_W{1'b0}});
        pop_s      = valid_q && pop_ready_i;
        push_acc_s = push_i && (!full_s || pop_s);
        drop_s     = push_i && full_s && !pop_s;
        rd_next_s  = rd_ptr_q + PTR_W'(1);
        count_d    = count_q;
        if (push_acc_s && !pop_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_s && !push_acc_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Storage, pointers, registered head and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
            rd_ptr_q <= {PTR_W{1'b0}};
            wr_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            head_q   <= {W{1'b0}};
        end else begin
            if (push_acc_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_next_s;
            end
            // The head only moves on a pop or when an empty queue gets its first entry.
            if (push_acc_s && (empty_s || (pop_s && count_q == CNT_W'(1)))) begin
                head_q <= push_data_i;
            end else if (pop_s && count_q > CNT_W'(1)) begin
                head_q <= mem_q[rd_next_s];
            end
            if (drop_s) begin
                ovf_q <= 1'b1;
            end
            count_q <= count_d;
            valid_q <= (count_d != {CNT_W{1'b0}});
        end
    end

    assign valid_o    = valid_q;
    assign head_o     = head_q;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/keypad_event_queue.sv
// Frame-level debounce of the 4x4 keypad scanner output feeding a small event
// FIFO. Define KEYPAD_RELEASE_EVENT_EN to also queue key-release events.
module keypad_event_queue
    import keypad_pkg::*;
#(
    parameter int STABLE_FRAMES  = 4,
    parameter int RELEASE_FRAMES = 4,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          scan_hit,
    input  logic [KEY_CODE_W-1:0]         scan_code,
    input  logic                          frame_end,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [KEY_CODE_W-1:0]         evt_code,
    output logic                          evt_release,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam logic [CNT_W-1:0] STABLE_C  = CNT_W'(STABLE_FRAMES);
    localparam logic [CNT_W-1:0] RELEASE_C = CNT_W'(RELEASE_FRAMES);
`ifdef KEYPAD_RELEASE_EVENT_EN
    localparam int EVT_W = KEY_CODE_W + 1;
`else
    localparam int EVT_W = KEY_CODE_W;
`endif

    logic                  any_hit_q;
    logic                  multi_q;
    logic [KEY_CODE_W-1:0] first_code_q;
    logic                  frame_any_s;
    logic                  frame_multi_s;
    logic [KEY_CODE_W-1:0] frame_code_s;
    frame_res_e            frame_res_s;

    key_state_e            state_q;
    logic [KEY_CODE_W-1:0] cand_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      rcnt_q;
    logic                  press_done_s;
    logic                  rel_done_s;
    logic                  push_s;
    logic [EVT_W-1:0]      push_data_s;
    logic [EVT_W-1:0]      head_s;

    // Frame result including the sample presented on the frame_end cycle.
    always_comb begin
        frame_any_s   = any_hit_q | scan_hit;
        frame_multi_s = multi_q | (any_hit_q & scan_hit & (scan_code != first_code_q));
        if (any_hit_q) begin
            frame_code_s = first_code_q;
        end else if (scan_hit) begin
            frame_code_s = scan_code;
        end else begin
            frame_code_s = {KEY_CODE_W{1'b0}};
        end
        if (!frame_any_s) begin
            frame_res_s = FR_NONE;
        end else if (frame_multi_s) begin
            frame_res_s = FR_MULTI;
        end else begin
            frame_res_s = FR_ONE;
        end
    end

    // Per-frame accumulator, cleared after every frame_end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            any_hit_q    <= 1'b0;
            multi_q      <= 1'b0;
            first_code_q <= {KEY_CODE_W{1'b0}};
        end else if (frame_end) begin
            any_hit_q    <= 1'b0;
            multi_q      <= 1'b0;
            first_code_q <= {KEY_CODE_W{1'b0}};
        end else begin
            any_hit_q    <= frame_any_s;
            multi_q      <= frame_multi_s;
            first_code_q <= frame_code_s;
        end
    end

    // Debounce completion is decided in the frame_end cycle so the event lands one clock later.
    always_comb begin
        press_done_s = 1'b0;
        rel_done_s   = 1'b0;
        if (frame_end) begin
            case (state_q)
                KS_CAND: begin
                    press_done_s = (frame_res_s == FR_ONE) && (frame_code_s == cand_q)
                                   && (sat_inc(cnt_q) >= STABLE_C);
                end
                KS_PRESSED: begin
                    rel_done_s = (frame_res_s == FR_NONE) && (sat_inc(rcnt_q) >= RELEASE_C);
                end
                default: begin
                    press_done_s = 1'b0;
                    rel_done_s   = 1'b0;
                end
            endcase
        end else begin
            press_done_s = 1'b0;
            rel_done_s   = 1'b0;
        end
`ifdef KEYPAD_RELEASE_EVENT_EN
        push_s      = press_done_s | rel_done_s;
        push_data_s = {cand_q, rel_done_s};
`else
        push_s      = press_done_s;
        push_data_s = cand_q;
`endif
    end

    // Debounce FSM, advanced once per scan frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= KS_IDLE;
            cand_q  <= {KEY_CODE_W{1'b0}};
            cnt_q   <= {CNT_W{1'b0}};
            rcnt_q  <= {CNT_W{1'b0}};
        end else if (frame_end) begin
            case (state_q)
                KS_IDLE: begin
                    if (frame_res_s == FR_ONE) begin
                        state_q <= KS_CAND;
                        cand_q  <= frame_code_s;
                        cnt_q   <= 4'd1;
                    end
                end
                KS_CAND: begin
                    if (frame_res_s == FR_ONE) begin
                        if (frame_code_s != cand_q) begin
                            cand_q <= frame_code_s;
                            cnt_q  <= 4'd1;
                        end else if (press_done_s) begin
                            state_q <= KS_PRESSED;
                            cnt_q   <= 4'd0;
                            rcnt_q  <= 4'd0;
                        end else begin
                            cnt_q <= sat_inc(cnt_q);
                        end
                    end else begin
                        state_q <= KS_IDLE;
                        cnt_q   <= 4'd0;
                    end
                end
                KS_PRESSED: begin
                    // Any key activity while held restarts the release count; no repeats.
                    if (frame_res_s != FR_NONE) begin
                        rcnt_q <= 4'd0;
                    end else if (rel_done_s) begin
                        state_q <= KS_IDLE;
                        rcnt_q  <= 4'd0;
                    end else begin
                        rcnt_q <= sat_inc(rcnt_q);
                    end
                end
                default: begin
                    state_q <= KS_IDLE;
                    cnt_q   <= 4'd0;
                    rcnt_q  <= 4'd0;
                end
            endcase
        end
    end

    keypad_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EVT_W)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_s),
        .push_data_i (push_data_s),
        .pop_ready_i (evt_ready),
        .valid_o     (evt_valid),
        .head_o      (head_s),
        .count_o     (fifo_count),
        .overflow_o  (overflow)
    );

`ifdef KEYPAD_RELEASE_EVENT_EN
    key_evt_t head_evt_s;
    assign head_evt_s  = head_s;
    assign evt_code    = head_evt_s.code;
    assign evt_release = head_evt_s.is_release;
`else
    assign evt_code    = head_s;
    assign evt_release = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_event_queue.sv
// Randomised and directed bench for keypad_event_queue against a frame-level
// reference model (set of hits per frame, run counters, event queue).
module tb_keypad_event_queue;

    localparam int SF    = 4;
    localparam int RF    = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          scan_hit = 1'b0;
    logic [3:0]    scan_code = 4'h0;
    logic          frame_end = 1'b0;
    logic          evt_ready = 1'b0;
    logic          evt_valid;
    logic [3:0]    evt_code;
    logic          evt_release;
    logic          overflow;
    logic [CW-1:0] fifo_count;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: key phase, candidate, frame runs, event queue.
    int         m_phase;
    logic [3:0] m_key;
    int         m_run;
    int         m_quiet;
    bit         m_ovf;
    logic [4:0] m_q[$];
    logic [3:0] m_hits[$];

    keypad_event_queue #(
        .STABLE_FRAMES (SF),
        .RELEASE_FRAMES(RF),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .scan_hit   (scan_hit),
        .scan_code  (scan_code),
        .frame_end  (frame_end),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_release(evt_release),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_key   = 4'h0;
        m_run   = 0;
        m_quiet = 0;
        m_ovf   = 1'b0;
        m_q.delete();
        m_hits.delete();
    endtask

    task automatic model_step(input logic h, input logic [3:0] c, input logic fe, input logic r);
        bit         do_pop;
        bit         do_push;
        logic [4:0] ev;
        int         kind;
        do_pop  = (m_q.size() > 0) && r;
        do_push = 1'b0;
        ev      = 5'h0;
        if (h) m_hits.push_back(c);
        if (fe) begin
            kind = (m_hits.size() == 0) ? 0 : 1;
            foreach (m_hits[i]) if (m_hits[i] != m_hits[0]) kind = 2;
            if (m_phase == 0) begin
                if (kind == 1) begin m_phase = 1; m_key = m_hits[0]; m_run = 1; end
            end else if (m_phase == 1) begin
                if (kind == 1 && m_hits[0] == m_key) begin
                    m_run++;
                    if (m_run == SF) begin m_phase = 2; m_quiet = 0; do_push = 1'b1; ev = {m_key, 1'b0}; end
                end else if (kind == 1) begin
                    m_key = m_hits[0]; m_run = 1;
                end else begin
                    m_phase = 0;
                end
            end else begin
                if (kind == 0) begin
                    m_quiet++;
                    if (m_quiet == RF) begin
                        m_phase = 0;
`ifdef KEYPAD_RELEASE_EVENT_EN
                        do_push = 1'b1; ev = {m_key, 1'b1};
`endif
                    end
                end else begin
                    m_quiet = 0;
                end
            end
            m_hits.delete();
        end
        if (do_pop) void'(m_q.pop_front());
        if (do_push) begin
            if (m_q.size() < DEPTH) m_q.push_back(ev);
            else m_ovf = 1'b1;
        end
    endtask

    task automatic compare_outputs();
        check_eq("evt_valid", 32'(evt_valid), 32'(m_q.size() > 0));
        check_eq("fifo_count", 32'(fifo_count), 32'(m_q.size()));
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        if (m_q.size() > 0) begin
            check_eq("evt_code", 32'(evt_code), 32'(m_q[0][4:1]));
            check_eq("evt_release", 32'(evt_release), 32'(m_q[0][0]));
        end
    endtask

    task automatic cycle(input logic h, input logic [3:0] c, input logic fe, input logic r);
        scan_hit  = h;
        scan_code = c;
        frame_end = fe;
        evt_ready = r;
        @(posedge clk);
        model_step(h, c, fe, r);
        #1;
        compare_outputs();
    endtask

    function automatic logic pick_ready(input int mode);
        if (mode == 0) return 1'b0;
        if (mode == 1) return 1'b1;
        return ($urandom_range(0, 2) == 0);
    endfunction

    // nk keys per frame: 0 none, 1 key a, 2 keys a and b on different samples.
    task automatic do_frame(input int len, input int nk, input logic [3:0] a, input logic [3:0] b,
                            input int rmode);
        int         ia;
        int         ib;
        logic       h;
        logic [3:0] c;
        ia = int'(a[3:2]) % len;
        ib = int'(b[3:2]) % len;
        if (nk == 2 && ib == ia) ib = (ia + 1) % len;
        for (int i = 0; i < len; i++) begin
            h = 1'b0;
            c = 4'($urandom_range(0, 15));
            if (nk >= 1 && i == ia) begin
                h = 1'b1; c = a;
            end else if (nk == 2 && len > 1 && i == ib) begin
                h = 1'b1; c = b;
            end
            cycle(h, c, (i == len - 1), pick_ready(rmode));
        end
    endtask

    task automatic idle(input int n, input int rmode);
        for (int i = 0; i < n; i++) cycle(1'b0, 4'($urandom_range(0, 15)), 1'b0, pick_ready(rmode));
    endtask

    task automatic press_key(input logic [3:0] k, input int frames, input int rmode);
        for (int i = 0; i < frames; i++) do_frame(4, 1, k, 4'h0, rmode);
    endtask

    initial begin
        logic [3:0] cur;
        int         sel;
        model_reset();
        #2;
        check_eq("rst_valid", 32'(evt_valid), 32'd0);
        check_eq("rst_count", 32'(fifo_count), 32'd0);
        check_eq("rst_code", 32'(evt_code), 32'd0);
        check_eq("rst_release", 32'(evt_release), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Stable key 0x6 for four frames gives a single press one clock after frame_end.
        press_key(4'h6, 3, 0);
        check_eq("t1_early", 32'(evt_valid), 32'd0);
        press_key(4'h6, 1, 0);
        check_eq("t1_valid", 32'(evt_valid), 32'd1);
        check_eq("t1_code", 32'(evt_code), 32'h6);
        check_eq("t1_rel", 32'(evt_release), 32'd0);
        press_key(4'h6, 3, 0);
        check_eq("t1_norepeat", 32'(fifo_count), 32'd1);
        press_key(4'h0, 0, 0);
        for (int i = 0; i < RF; i++) do_frame(4, 0, 4'h0, 4'h0, 0);
        idle(4, 1);

        // Interrupted burst must restart the count.
        press_key(4'h6, 3, 0);
        do_frame(4, 0, 4'h0, 4'h0, 0);
        press_key(4'h6, 3, 0);
        check_eq("t2_none", 32'(fifo_count), 32'd0);
        press_key(4'h6, 1, 0);
        check_eq("t2_press", 32'(fifo_count), 32'd1);
        for (int i = 0; i < RF; i++) do_frame(4, 0, 4'h0, 4'h0, 0);
        idle(4, 1);

        // Two keys in one frame are rejected.
        for (int i = 0; i < 6; i++) do_frame(4, 2, 4'h2, 4'hB, 0);
        check_eq("t3_multi", 32'(fifo_count), 32'd0);

        // Five distinct presses with the consumer stalled.
        for (int k = 0; k < 5; k++) begin
            press_key(4'(4'h1 + k * 3), SF, 0);
            for (int i = 0; i < RF; i++) do_frame(4, 0, 4'h0, 4'h0, 0);
        end
        check_eq("t4_count", 32'(fifo_count), 32'(DEPTH));
        check_eq("t4_ovf", 32'(overflow), 32'd1);
        idle(DEPTH + 2, 1);

        // Press and release of 0xF.
        press_key(4'hF, SF, 0);
        for (int i = 0; i < RF; i++) do_frame(4, 0, 4'h0, 4'h0, 0);
        idle(4, 1);

        // Async reset while a candidate is pending and events are queued.
        press_key(4'h9, SF, 0);
        for (int i = 0; i < RF; i++) do_frame(4, 0, 4'h0, 4'h0, 0);
        press_key(4'hA, SF, 0);
        for (int i = 0; i < RF; i++) do_frame(4, 0, 4'h0, 4'h0, 0);
        press_key(4'h3, 2, 0);
        check_eq("t6_queued", 32'(fifo_count >= 2), 32'd1);
        scan_hit = 1'b0;
        frame_end = 1'b0;
        evt_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_valid", 32'(evt_valid), 32'd0);
        check_eq("t6_count", 32'(fifo_count), 32'd0);
        check_eq("t6_ovf", 32'(overflow), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        press_key(4'h3, SF - 1, 0);
        check_eq("t6_restart", 32'(evt_valid), 32'd0);
        press_key(4'h3, 1, 0);
        check_eq("t6_press", 32'(evt_valid), 32'd1);
        check_eq("t6_code", 32'(evt_code), 32'h3);
        idle(6, 1);

        // Random frames of varying length with a random consumer.
        cur = 4'($urandom_range(0, 15));
        for (int f = 0; f < 400; f++) begin
            if ($urandom_range(0, 9) == 0) cur = 4'($urandom_range(0, 15));
            sel = $urandom_range(0, 9);
            if (sel < 6)
                do_frame($urandom_range(1, 4), 1, cur, 4'h0, 2);
            else if (sel < 9)
                do_frame($urandom_range(1, 4), 0, 4'h0, 4'h0, 2);
            else
                do_frame($urandom_range(2, 4), 2, cur, 4'(cur + 4'h5), 2);
            if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3), 2);
        end
        idle(8, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
